// File: rtl/bram_sdp_stream_reader.sv
// bram_sdp_stream_reader
//
// Reads a run of consecutive words from the read port of a simple-dual-port
// BRAM and presents them as a valid/ready stream. Reads are issued only when
// the output FIFO is guaranteed to have room for every word still in flight,
// so the downstream consumer may stall at any time without data loss.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      single-cycle transfer request (honoured only when idle)
//   base_addr  first BRAM address, sampled with start
//   length     number of words to read, sampled with start (0 is legal)
//   busy       high while a transfer is issuing or draining
//   done       one-cycle completion pulse (busy is low in that cycle)
//   rd_addr    BRAM RDADDR
//   rd_en      BRAM RDEN
//   rd_regce   BRAM REGCE, held high for the whole transfer
//   rd_data    BRAM DO
//   m_data     stream data
//   m_valid    stream valid
//   m_last     marks the final word of the transfer
//   m_ready    stream ready from the consumer
module bram_sdp_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int LEN_WIDTH    = ADDR_WIDTH + 1,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  rd_regce,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    remain_q, remain_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    acc_q, acc_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [CNT_W-1:0]        outstanding;
  logic                    credit_ok;
  logic                    fifo_push;
  logic                    fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Stage: read issue. A read is allowed only if every word already in
  // flight plus every word buffered still leaves a free FIFO slot.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + CNT_W'(vld_pipe_q[i]);
    end
  end

  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_cnt_q}) < DEPTH_C;
  assign rd_en     = (state_q == ST_ISSUE) && credit_ok;
  assign rd_addr   = addr_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign rd_regce  = busy;
  assign done      = (state_q == ST_FINISH);

  // Stage: stream output from the FIFO head.
  assign m_valid   = (fifo_cnt_q != '0);
  assign m_data    = fifo_mem_q[rd_ptr_q];
  assign m_last    = m_valid && ((acc_q + LEN_WIDTH'(1)) == len_q);
  assign fifo_pop  = m_valid && m_ready;
  assign fifo_push = vld_pipe_q[READ_LATENCY-1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    len_d    = len_q;
    acc_d    = fifo_pop ? acc_q + LEN_WIDTH'(1) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
          len_d    = length;
          acc_d    = '0;
          state_d  = (length == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_en) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Nothing in flight and the only buffered word is the last one
        // being accepted right now: the transfer is complete.
        if ((outstanding == '0) && (fifo_cnt_q == CNT_W'(1)) && fifo_pop && m_last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Stage: BRAM latency pipe. Bit i is set when the read issued i+1 cycles
  // ago is still on its way; the top bit marks rd_data as valid now.
  always_comb begin
    vld_pipe_d[0] = rd_en;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  // Stage: FIFO bookkeeping; push and pop in the same cycle leave the count.
  always_comb begin
    wr_ptr_d = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (fifo_push) begin
        fifo_mem_q[wr_ptr_q] <= rd_data;
      end
    end
  end

endmodule

// File: doc/bram_sdp_stream_reader.md
BRAM_SDP_STREAM_READER -- requirements
Module: bram_sdp_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the BRAM read data width and the stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, the BRAM read address width.
REQ-003 SHALL have parameter LEN_WIDTH, default ADDR_WIDTH+1, the transfer length width, so a full-memory read is expressible.
REQ-004 SHALL have parameter READ_LATENCY, default 2, the cycles from RDEN high to valid DO (2 when the BRAM output register is on, 1 when off).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, the output buffer depth; it SHALL be at least READ_LATENCY+1.
REQ-006 clk  input  1  the single clock; all logic is on the rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle request to begin a transfer.
REQ-009 base_addr  input  ADDR_WIDTH  first BRAM address, sampled with start.
REQ-010 length  input  LEN_WIDTH  number of words to read, sampled with start.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when the transfer completes.
REQ-013 rd_addr  output  ADDR_WIDTH  drives the BRAM RDADDR.
REQ-014 rd_en  output  1  drives the BRAM RDEN.
REQ-015 rd_regce  output  1  drives the BRAM REGCE; it is high continuously while busy.
REQ-016 rd_data  input  DATA_WIDTH  driven by the BRAM DO.
REQ-017 m_data  output  DATA_WIDTH  stream data.
REQ-018 m_valid  output  1  stream valid.
REQ-019 m_last  output  1  high with the final word of a transfer.
REQ-020 m_ready  input  1  stream ready from the downstream consumer.

Function
REQ-021 SHALL implement states IDLE, ISSUE, DRAIN and FINISH.
- IDLE -> ISSUE on start with length>0.
- IDLE -> FINISH on start with length=0.
- ISSUE -> DRAIN after the last read is issued.
- DRAIN -> FINISH when the outstanding count, FIFO count and the m_valid/m_ready final handshake are all complete.
- FINISH -> IDLE unconditionally.
REQ-022 SHALL ignore start in any state other than IDLE.
REQ-023 SHALL issue a read in ISSUE only when outstanding + fifo_count < FIFO_DEPTH.
- Issuing a read means rd_en=1 and rd_addr equals the current address.
- Each issue increments the address, which wraps modulo 2^ADDR_WIDTH.
REQ-024 SHALL capture rd_data into the FIFO exactly READ_LATENCY cycles after each rd_en, using a READ_LATENCY-deep valid shift register.
REQ-025 SHALL assert the first rd_en in the cycle after start is sampled; with READ_LATENCY=2 and m_ready=1, the first m_valid SHALL be in cycle 4 after the start edge.
REQ-026 SHALL sustain one word per cycle when m_ready is held high.
REQ-027 SHALL hold m_data, m_valid and m_last stable while m_valid=1 and m_ready=0.
REQ-028 SHALL never overflow the FIFO under any m_ready pattern; the credit rule in REQ-023 guarantees this.
REQ-029 SHALL count accepted words in a LEN_WIDTH counter and assert m_last on word number length.
REQ-030 SHALL handle simultaneous FIFO push and pop in one cycle with fifo_count unchanged.
REQ-031 SHALL assert done for exactly one cycle in FINISH; busy SHALL be low in that same cycle.

Reset
REQ-032 SHALL, while resetn=0, force state IDLE and clear all counters, the FIFO and the latency pipe.
REQ-033 SHALL hold busy, done, rd_en, rd_regce, m_valid, m_last, rd_addr and m_data at 0 while resetn=0.
REQ-034 SHALL abort a transfer in progress when reset is asserted mid-operation, with no done pulse; after release it SHALL accept a new start normally.

Verification
REQ-035 Bench SHALL apply base=3, length=5, m_ready=1 and check: m_data = mem[3..7] in consecutive cycles, m_last on the 5th word, done 1 cycle after the last handshake.
REQ-036 Bench SHALL apply base=14, length=4 and check that addresses 14, 15, 0, 1 are read in that order.
REQ-037 Bench SHALL apply length=16 with m_ready toggling randomly and check: all 16 words in order, no loss, no duplicates, FIFO count never above 4.
REQ-038 Bench SHALL apply length=0 and check: done in cycle 1, no rd_en and no m_valid.
REQ-039 Bench SHALL apply a second start while busy and check that it is ignored and the first transfer completes unchanged.
REQ-040 Bench SHALL assert resetn=0 after the 3rd word of a length=8 transfer and check: all outputs 0 and no done; a following start with base=0, length=2 returns mem[0], mem[1].
